core_mem_port: RTL and testbench

- Per-core memory request stage that sits directly upstream of the sixteen bank arbiters. One instance per core.
- Takes one byte read/write request at a time from the core pipeline. Drives that core's read/write strobe and its 12-bit address / 8-bit data slice into the shared arbiter buses.
- Holds the request stable until the addressed bank's arbiter returns the finish pulse for this core, then returns read data and a one-cycle response.
- A watchdog aborts requests that are never served.

---
 rtl/core_mem_port.sv | 133 +++++++++++++
 tb/tb_core_mem_port.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_port.sv
// Per-core memory request stage: holds one byte request on the shared arbiter buses
// until the addressed bank's arbiter signals finish, or until the watchdog aborts it.
module core_mem_port #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_valid,
    input  logic         req_write,
    input  logic [11:0]  req_addr,
    input  logic [7:0]   req_wdata,
    output logic         req_ready,
    output logic         resp_valid,
    output logic [7:0]   resp_rdata,
    output logic         resp_timeout,
    output logic         mem_read,
    output logic         mem_write,
    output logic [11:0]  mem_addr,
    output logic [7:0]   mem_wdata,
    input  logic [15:0]  bank_finish,
    input  logic [127:0] bank_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic             write_q;
    logic [11:0]      addr_q;
    logic [7:0]       wdata_q;
    logic [7:0]       rdata_q;
    logic [CNT_W-1:0] count;
    logic             timeout_q;

    logic [3:0]       bank;
    logic             hit;
    logic             expire;
    logic [7:0]       bank_byte;

    // Only the addressed bank's finish bit and data byte matter; other arbiters
    // may present unrelated nonzero values for this core.
    assign bank      = addr_q[11:8];
    assign hit       = bank_finish[bank];
    assign bank_byte = bank_rdata[{bank, 3'b000} +: 8];
    assign expire    = (count == LAST_COUNT);

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign resp_rdata = rdata_q;

    always_comb begin
        state_next   = state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_timeout = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // Strobe drops in the hit cycle so the arbiter cannot serve the request twice.
                mem_read  = ~write_q & ~hit;
                mem_write = write_q & ~hit;
                if (hit || expire) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid   = 1'b1;
                resp_timeout = timeout_q;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            count     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        count   <= '0;
                    end
                end
                ISSUE: begin
                    // A hit on the expiry cycle is a normal completion.
                    if (hit) begin
                        rdata_q   <= write_q ? 8'h00 : bank_byte;
                        timeout_q <= 1'b0;
                    end else if (expire) begin
                        rdata_q   <= 8'h00;
                        timeout_q <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RESP: begin
                    timeout_q <= 1'b0;
                end
                default: begin
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem_port.sv
// Directed bench for core_mem_port: a transaction-level model is compared every cycle,
// and each scenario also pins hand-computed literal results.
module tb_core_mem_port;

    localparam int TO = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_write;
    logic [11:0]  req_addr;
    logic [7:0]   req_wdata;
    logic         req_ready;
    logic         resp_valid;
    logic [7:0]   resp_rdata;
    logic         resp_timeout;
    logic         mem_read;
    logic         mem_write;
    logic [11:0]  mem_addr;
    logic [7:0]   mem_wdata;
    logic [15:0]  bank_finish;
    logic [127:0] bank_rdata;

    core_mem_port #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_timeout (resp_timeout),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .bank_finish  (bank_finish),
        .bank_rdata   (bank_rdata)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction model: one outstanding request, cycles waited, response due.
    bit          m_busy;
    bit          m_resp;
    bit          m_to;
    bit          m_write;
    logic [11:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata;
    int          m_wait;

    // Observations accumulated per scenario.
    int          rd_cycles;
    int          wr_cycles;
    int          resp_cnt;
    logic [7:0]  seen_rdata;
    logic        seen_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hit();
        int b;
        b = int'(m_addr[11:8]);
        return bank_finish[b];
    endfunction

    function automatic logic [7:0] m_byte();
        int b;
        b = int'(m_addr[11:8]);
        return bank_rdata[b*8 +: 8];
    endfunction

    task automatic compare_model();
        check("req_ready",    {31'd0, req_ready},    {31'd0, (!m_busy && !m_resp)});
        check("resp_valid",   {31'd0, resp_valid},   {31'd0, m_resp});
        check("resp_timeout", {31'd0, resp_timeout}, {31'd0, (m_resp && m_to)});
        check("resp_rdata",   {24'd0, resp_rdata},   {24'd0, m_rdata});
        check("mem_read",     {31'd0, mem_read},     {31'd0, (m_busy && !m_write && !m_hit())});
        check("mem_write",    {31'd0, mem_write},    {31'd0, (m_busy && m_write && !m_hit())});
        check("mem_addr",     {20'd0, mem_addr},     {20'd0, m_addr});
        check("mem_wdata",    {24'd0, mem_wdata},    {24'd0, m_wdata});
    endtask

    task automatic model_update();
        if (reset) begin
            m_busy  = 0;
            m_resp  = 0;
            m_to    = 0;
            m_write = 0;
            m_addr  = '0;
            m_wdata = '0;
            m_rdata = '0;
            m_wait  = 0;
        end else if (m_resp) begin
            m_resp = 0;
        end else if (m_busy) begin
            if (m_hit()) begin
                m_rdata = m_write ? 8'h00 : m_byte();
                m_to    = 0;
                m_resp  = 1;
                m_busy  = 0;
            end else if (m_wait + 1 == TO) begin
                m_rdata = 8'h00;
                m_to    = 1;
                m_resp  = 1;
                m_busy  = 0;
            end else begin
                m_wait++;
            end
        end else if (req_valid) begin
            m_busy  = 1;
            m_write = req_write;
            m_addr  = req_addr;
            m_wdata = req_wdata;
            m_wait  = 0;
        end
    endtask

    task automatic clear_obs();
        rd_cycles  = 0;
        wr_cycles  = 0;
        resp_cnt   = 0;
        seen_rdata = 8'hEE;
        seen_to    = 1'bx;
    endtask

    // One clock cycle: inputs already applied after a falling edge.
    task automatic step();
        #2;
        compare_model();
        rd_cycles += int'(mem_read);
        wr_cycles += int'(mem_write);
        if (resp_valid) begin
            resp_cnt++;
            seen_rdata = resp_rdata;
            seen_to    = resp_timeout;
        end
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic drive(input logic v, input logic w, input logic [11:0] a,
                         input logic [7:0] d, input logic [15:0] fin);
        req_valid   = v;
        req_write   = w;
        req_addr    = a;
        req_wdata   = d;
        bank_finish = fin;
    endtask

    initial begin
        reset      = 1'b1;
        drive(1'b0, 1'b0, 12'h000, 8'h00, 16'h0000);
        bank_rdata = '0;
        @(posedge clock);
        model_update();
        @(negedge clock);
        #1;
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rd",    {31'd0, mem_read},  32'd0);
        check("reset_addr",  {20'd0, mem_addr},  32'd0);
        step();
        reset = 1'b0;
        step();

        // Load to bank 3, finish after 4 waiting cycles.
        clear_obs();
        drive(1'b1, 1'b0, 12'h3A5, 8'h00, 16'h0000);
        step();
        drive(1'b0, 1'b0, 12'h000, 8'h00, 16'h0000);
        for (int i = 0; i < 4; i++) step();
        drive(1'b0, 1'b0, 12'h000, 8'h00, 16'h0008);
        bank_rdata[3*8 +: 8] = 8'h5C;
        #1;
        check("load_hit_rd_low", {31'd0, mem_read}, 32'd0);
        step();
        drive(1'b0, 1'b0, 12'h000, 8'h00, 16'h0000);
        step();
        step();
        check("load_rd_cycles", rd_cycles,           32'd4);
        check("load_resp_cnt",  resp_cnt,            32'd1);
        check("load_rdata",     {24'd0, seen_rdata}, 32'h5C);
        check("load_to",        {31'd0, seen_to},    32'd0);

        // Store to bank 0, finish after 2 waiting cycles.
        clear_obs();
        bank_rdata = '0;
        bank_rdata[0 +: 8] = 8'h66;
        drive(1'b1, 1'b1, 12'h0F1, 8'hAB, 16'h0000);
        step();
        drive(1'b0, 1'b0, 12'h000, 8'h00, 16'h0000);
        #1;
        check("store_wr",    {31'd0, mem_write}, 32'd1);
        check("store_addr",  {20'd0, mem_addr},  32'h0F1);
        check("store_wdata", {24'd0, mem_wdata}, 32'hAB);
        for (int i = 0; i < 2; i++) step();
        drive(1'b0, 1'b0, 12'h000, 8'h00, 16'h0001);
        step();
        drive(1'b0, 1'b0, 12'h000, 8'h00, 16'h0000);
        step();
        step();
        check("store_wr_cycles", wr_cycles,           32'd2);
        check("store_rd_cycles", rd_cycles,           32'd0);
        check("store_resp_cnt",  resp_cnt,            32'd1);
        check("store_rdata",     {24'd0, seen_rdata}, 32'h00);

        // Load to bank 5 while bank 4 reports finish and data for this core.
        clear_obs();
        bank_rdata = '0;
        drive(1'b1, 1'b0, 12'h512, 8'h00, 16'h0000);
        step();
        drive(1'b0, 1'b0, 12'h000, 8'h00, 16'h0010);
        bank_rdata[4*8 +: 8] = 8'hFF;
        for (int i = 0; i < 3; i++) step();
        drive(1'b0, 1'b0, 12'h000, 8'h00, 16'h0020);
        bank_rdata[5*8 +: 8] = 8'h11;
        step();
        drive(1'b0, 1'b0, 12'h000, 8'h00, 16'h0000);
        step();
        step();
        check("wrong_bank_rd_cycles", rd_cycles,           32'd3);
        check("wrong_bank_resp_cnt",  resp_cnt,            32'd1);
        check("wrong_bank_rdata",     {24'd0, seen_rdata}, 32'h11);

        // Watchdog: load to bank 2 with no finish ever.
        clear_obs();
        bank_rdata = '0;
        drive(1'b1, 1'b0, 12'h240, 8'h00, 16'h0000);
        step();
        drive(1'b0, 1'b0, 12'h000, 8'h00, 16'h0000);
        for (int i = 0; i < TO + 1; i++) step();
        check("to_rd_cycles", rd_cycles,           TO);
        check("to_resp_cnt",  resp_cnt,            32'd1);
        check("to_flag",      {31'd0, seen_to},    32'd1);
        check("to_rdata",     {24'd0, seen_rdata}, 32'h00);
        #1;
        check("to_ready_after", {31'd0, req_ready}, 32'd1);
        step();

        // Reset during a store, then a late finish from the addressed bank.
        clear_obs();
        drive(1'b1, 1'b1, 12'h7C3, 8'h5A, 16'h0000);
        step();
        drive(1'b0, 1'b0, 12'h000, 8'h00, 16'h0000);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 1'b0, 12'h000, 8'h00, 16'h0080);
        #1;
        check("rst_wr_low", {31'd0, mem_write}, 32'd0);
        check("rst_addr",   {20'd0, mem_addr},  32'd0);
        check("rst_wdata",  {24'd0, mem_wdata}, 32'd0);
        step();
        drive(1'b0, 1'b0, 12'h000, 8'h00, 16'h0000);
        step();
        step();
        check("rst_wr_cycles", wr_cycles, 32'd3);
        check("rst_resp_cnt",  resp_cnt,  32'd0);

        // Back-to-back loads with req_valid held high.
        clear_obs();
        bank_rdata = '0;
        bank_rdata[1*8 +: 8] = 8'h77;
        bank_rdata[9*8 +: 8] = 8'h99;
        drive(1'b1, 1'b0, 12'h110, 8'h00, 16'h0000);
        step();
        drive(1'b1, 1'b0, 12'h922, 8'h00, 16'h0002);
        #1;
        check("b2b_ready_issue", {31'd0, req_ready}, 32'd0);
        step();
        drive(1'b1, 1'b0, 12'h922, 8'h00, 16'h0000);
        #1;
        check("b2b_ready_resp", {31'd0, req_ready}, 32'd0);
        check("b2b_rdata1",     {24'd0, resp_rdata}, 32'h77);
        step();
        #1;
        check("b2b_ready_idle", {31'd0, req_ready}, 32'd1);
        step();
        drive(1'b0, 1'b0, 12'h000, 8'h00, 16'h0000);
        #1;
        check("b2b_addr2", {20'd0, mem_addr}, 32'h922);
        check("b2b_rd2",   {31'd0, mem_read}, 32'd1);
        step();
        drive(1'b0, 1'b0, 12'h000, 8'h00, 16'h0200);
        step();
        drive(1'b0, 1'b0, 12'h000, 8'h00, 16'h0000);
        step();
        step();
        check("b2b_resp_cnt", resp_cnt,            32'd2);
        check("b2b_rdata2",   {24'd0, seen_rdata}, 32'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
